// File: rtl/mem_arbiter.sv
// Two-port (CPU / DMA) memory arbiter with round-robin tie breaking and a
// fixed, parameterised access latency. One transaction is in flight at a time.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | no owner; sample requests and pick a winner
//   ACCESS | memory enabled for the owner, count runs down to zero
//   DONE   | one-cycle completion pulse to the owner, then back to IDLE
module mem_arbiter #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_done,
  output logic [31:0] dma_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam logic [1:0] CNT_LOAD = 2'(LATENCY - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_count;
  logic        r_owner_dma;
  logic        r_last_dma;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_cpu_rdata;
  logic [31:0] r_dma_rdata;
  logic        w_start;
  logic        w_win_dma;
  logic        w_last_beat;

  // Round-robin pick: DMA wins alone, or on a tie when CPU was granted last.
  always_comb begin
    w_win_dma   = dma_req && (!cpu_req || !r_last_dma);
    w_start     = (r_state == S_IDLE) && (cpu_req || dma_req);
    w_last_beat = (r_state == S_ACCESS) && (r_count == 2'd0);
  end

  // Next-state logic; DONE always returns to IDLE so no grant is issued there.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (cpu_req || dma_req) w_state_nxt = S_ACCESS;
      S_ACCESS: if (r_count == 2'd0) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Transaction latch, latency counter, arbitration history and read capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= 2'd0;
      r_owner_dma <= 1'b0;
      r_last_dma  <= 1'b1;
      r_we        <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_cpu_rdata <= 32'd0;
      r_dma_rdata <= 32'd0;
    end else begin
      if (w_start) begin
        r_owner_dma <= w_win_dma;
        r_last_dma  <= w_win_dma;
        r_count     <= CNT_LOAD;
        r_we        <= w_win_dma ? dma_we    : cpu_we;
        r_addr      <= w_win_dma ? dma_addr  : cpu_addr;
        r_wdata     <= w_win_dma ? dma_wdata : cpu_wdata;
      end else if ((r_state == S_ACCESS) && (r_count != 2'd0)) begin
        r_count <= r_count - 2'd1;
      end
      if (w_last_beat && !r_we) begin
        if (r_owner_dma) r_dma_rdata <= mem_rdata;
        else             r_cpu_rdata <= mem_rdata;
      end
    end
  end

  assign cpu_gnt   = (r_state != S_IDLE) && !r_owner_dma;
  assign dma_gnt   = (r_state != S_IDLE) &&  r_owner_dma;
  assign cpu_done  = (r_state == S_DONE) && !r_owner_dma;
  assign dma_done  = (r_state == S_DONE) &&  r_owner_dma;
  assign cpu_rdata = r_cpu_rdata;
  assign dma_rdata = r_dma_rdata;
  assign cpu_stall = cpu_req && !cpu_done;

  // Memory is word addressed on the bus; byte offset bits are dropped.
  assign mem_en    = (r_state == S_ACCESS);
  assign mem_we    = (r_state == S_ACCESS) && r_we;
  assign mem_addr  = r_addr & 32'hFFFF_FFFC;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one LATENCY=1 instance for the single-cycle read case
// and one LATENCY=3 instance checked against a transaction-level model.
module tb_mem_arbiter;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;

  logic        cpu_gnt_1, cpu_done_1, cpu_stall_1, dma_gnt_1, dma_done_1;
  logic        mem_en_1, mem_we_1;
  logic [31:0] cpu_rdata_1, dma_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;

  logic        cpu_gnt_3, cpu_done_3, cpu_stall_3, dma_gnt_3, dma_done_3;
  logic        mem_en_3, mem_we_3;
  logic [31:0] cpu_rdata_3, dma_rdata_3, mem_addr_3, mem_wdata_3, mem_rdata_3;

  int checks = 0;
  int errors = 0;

  // Memory seen by the LATENCY=3 instance, and the model's own view of it.
  logic [31:0] env_mem [0:7] = '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003,
                                 32'hC0DE0004, 32'hC0DE0005, 32'hC0DE0006, 32'hC0DE0007};
  logic [31:0] ref_mem [0:7];
  logic [31:0] exp_crd, exp_drd;
  bit          last_dma;

  always #5 clk = ~clk;

  mem_arbiter #(.LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt_1), .cpu_done(cpu_done_1), .cpu_rdata(cpu_rdata_1), .cpu_stall(cpu_stall_1),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt_1), .dma_done(dma_done_1), .dma_rdata(dma_rdata_1),
    .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
    .mem_rdata(mem_rdata_1)
  );

  mem_arbiter #(.LATENCY(LAT)) u_dut3 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt_3), .cpu_done(cpu_done_3), .cpu_rdata(cpu_rdata_3), .cpu_stall(cpu_stall_3),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt_3), .dma_done(dma_done_3), .dma_rdata(dma_rdata_3),
    .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
    .mem_rdata(mem_rdata_3)
  );

  assign mem_rdata_3 = env_mem[mem_addr_3[4:2]];

  always @(posedge clk) begin
    if (mem_en_3 && mem_we_3) env_mem[mem_addr_3[4:2]] <= mem_wdata_3;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset3(input string tag);
    chk({tag, "_cpu_gnt"},   cpu_gnt_3,   0);
    chk({tag, "_dma_gnt"},   dma_gnt_3,   0);
    chk({tag, "_cpu_done"},  cpu_done_3,  0);
    chk({tag, "_dma_done"},  dma_done_3,  0);
    chk({tag, "_mem_en"},    mem_en_3,    0);
    chk({tag, "_mem_we"},    mem_we_3,    0);
    chk({tag, "_mem_addr"},  mem_addr_3,  0);
    chk({tag, "_mem_wdata"}, mem_wdata_3, 0);
    chk({tag, "_cpu_rdata"}, cpu_rdata_3, 0);
    chk({tag, "_dma_rdata"}, dma_rdata_3, 0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cpu_gnt"},   cpu_gnt_3,   0);
    chk({tag, "_dma_gnt"},   dma_gnt_3,   0);
    chk({tag, "_cpu_done"},  cpu_done_3,  0);
    chk({tag, "_dma_done"},  dma_done_3,  0);
    chk({tag, "_mem_en"},    mem_en_3,    0);
    chk({tag, "_mem_we"},    mem_we_3,    0);
    chk({tag, "_stall"},     cpu_stall_3, cpu_req);
    chk({tag, "_cpu_rdata"}, cpu_rdata_3, exp_crd);
    chk({tag, "_dma_rdata"}, dma_rdata_3, exp_drd);
  endtask

  task automatic model_reset();
    last_dma = 1'b1;
    exp_crd  = 32'd0;
    exp_drd  = 32'd0;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
  endtask

  task automatic scramble_inputs();
    cpu_req   = 1'($urandom_range(0, 1));
    cpu_we    = 1'($urandom_range(0, 1));
    cpu_addr  = 32'($urandom_range(0, 31));
    cpu_wdata = $urandom;
    dma_req   = 1'($urandom_range(0, 1));
    dma_we    = 1'($urandom_range(0, 1));
    dma_addr  = 32'($urandom_range(0, 31));
    dma_wdata = $urandom;
  endtask

  // Entered and left just after the falling edge of an IDLE cycle.
  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    chk_reset3("rst");
    chk("rst1_cpu_gnt",   cpu_gnt_1,   0);
    chk("rst1_dma_gnt",   dma_gnt_1,   0);
    chk("rst1_dma_done",  dma_done_1,  0);
    chk("rst1_mem_en",    mem_en_1,    0);
    chk("rst1_dma_rdata", dma_rdata_1, 0);
    reset = 1'b0;
    model_reset();
  endtask

  // One request opportunity in IDLE, followed (if granted) by the whole
  // transaction. abort_at=k asserts reset after the k-th ACCESS cycle.
  task automatic txn(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                     input bit dr, input bit dw, input logic [31:0] da, input logic [31:0] dd,
                     input bit scramble, input bit drop_cpu, input int abort_at);
    bit          w_dma, we;
    logic [31:0] a, d;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
    if (!cr && !dr) begin
      @(negedge clk);
      chk_idle("noreq");
      return;
    end
    w_dma    = dr && (!cr || !last_dma);
    last_dma = w_dma;
    we = w_dma ? dw : cw;
    a  = w_dma ? da : ca;
    d  = w_dma ? dd : cd;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      chk("acc_cpu_gnt",   cpu_gnt_3,   !w_dma);
      chk("acc_dma_gnt",   dma_gnt_3,   w_dma);
      chk("acc_mem_en",    mem_en_3,    1);
      chk("acc_mem_we",    mem_we_3,    we);
      chk("acc_mem_addr",  mem_addr_3,  {a[31:2], 2'b00});
      chk("acc_mem_wdata", mem_wdata_3, d);
      chk("acc_cpu_done",  cpu_done_3,  0);
      chk("acc_dma_done",  dma_done_3,  0);
      chk("acc_stall",     cpu_stall_3, cpu_req);
      if (k == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        chk_reset3("abort");
        reset = 1'b0;
        model_reset();
        return;
      end
      if (scramble) scramble_inputs();
      else if (drop_cpu) cpu_req = 1'b0;
    end
    @(negedge clk);
    if (we) ref_mem[a[4:2]] = d;
    else if (w_dma) exp_drd = ref_mem[a[4:2]];
    else exp_crd = ref_mem[a[4:2]];
    chk("done_cpu_done",  cpu_done_3,  !w_dma);
    chk("done_dma_done",  dma_done_3,  w_dma);
    chk("done_cpu_gnt",   cpu_gnt_3,   !w_dma);
    chk("done_dma_gnt",   dma_gnt_3,   w_dma);
    chk("done_mem_en",    mem_en_3,    0);
    chk("done_cpu_rdata", cpu_rdata_3, exp_crd);
    chk("done_dma_rdata", dma_rdata_3, exp_drd);
    chk("done_stall",     cpu_stall_3, cpu_req & w_dma);
    if (scramble) scramble_inputs();
    @(negedge clk);
    chk_idle("post_done");
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ref_mem[i] = 32'hC0DE0000 + 32'(i);
    mem_rdata_1 = 32'd45;
    reset = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    do_reset();

    // Single-cycle read on the LATENCY=1 instance.
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000000C;
    #1;
    chk("l1_stall_n", cpu_stall_1, 1);
    chk("l1_gnt_n",   cpu_gnt_1,   0);
    @(negedge clk);
    chk("l1_gnt_n1",   cpu_gnt_1,   1);
    chk("l1_mem_en_n1", mem_en_1,   1);
    chk("l1_addr_n1",  mem_addr_1,  32'h0000000C);
    chk("l1_done_n1",  cpu_done_1,  0);
    chk("l1_stall_n1", cpu_stall_1, 1);
    @(negedge clk);
    chk("l1_done_n2",  cpu_done_1,  1);
    chk("l1_rdata_n2", cpu_rdata_1, 32'd45);
    chk("l1_mem_en_n2", mem_en_1,   0);
    chk("l1_stall_n2", cpu_stall_1, 0);
    cpu_req = 0;
    @(negedge clk);
    chk("l1_gnt_n3",   cpu_gnt_1,   0);
    chk("l1_done_n3",  cpu_done_1,  0);
    do_reset();

    // Contention from reset: CPU, DMA, CPU, DMA.
    txn(1, 0, 32'h04, 0, 1, 0, 32'h08, 0, 0, 0, 0);
    chk("rr_first_cpu", cpu_rdata_3, 32'hC0DE0001);
    txn(1, 0, 32'h04, 0, 1, 0, 32'h08, 0, 0, 0, 0);
    chk("rr_second_dma", dma_rdata_3, 32'hC0DE0002);
    txn(1, 0, 32'h18, 0, 1, 0, 32'h1C, 0, 0, 0, 0);
    txn(1, 0, 32'h18, 0, 1, 0, 32'h1C, 0, 0, 0, 0);

    // Unaligned DMA write followed by an aligned CPU read-back.
    txn(0, 0, 0, 0, 1, 1, 32'h0E, 32'd10, 0, 0, 0);
    txn(1, 0, 32'h0C, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("wr_readback", cpu_rdata_3, 32'd10);

    // CPU withdraws its write request during ACCESS; DMA reads it back.
    txn(1, 1, 32'h10, 32'h12345678, 0, 0, 0, 0, 0, 1, 0);
    txn(0, 0, 0, 0, 1, 0, 32'h10, 0, 0, 0, 0);
    chk("drop_readback", dma_rdata_3, 32'h12345678);

    // Reset in the second ACCESS cycle, then normal operation resumes.
    txn(1, 0, 32'h14, 0, 0, 0, 0, 0, 0, 0, 2);
    txn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    txn(1, 0, 32'h14, 0, 1, 0, 32'h00, 0, 0, 0, 0);
    chk("post_abort_cpu_wins", cpu_rdata_3, 32'hC0DE0005);

    // Randomised traffic with inputs disturbed during transactions.
    for (int n = 0; n < 60; n++) begin
      txn(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 31)), $urandom,
          ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 31)), $urandom,
          1, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
